// File: rtl/uart_rx_data40.sv
// ----------------------------------------------------------------------------
// uart_rx_data40
//
// 8N1 UART receiver that collects five consecutive byte frames into one
// 40-bit word. The first byte received lands in Data40[7:0] and the fifth in
// Data40[39:32]. The serial line is synchronised, each frame is detected on a
// falling edge and its bits are sampled mid-bit. Frames that fail their stop
// bit, and partial words followed by a long idle gap, are dropped and
// reported on Rx_Err.
//
// Parameters
//   CLK_FREQ      system clock frequency in Hz
//   BAUD          serial bit rate
//   TIMEOUT_BITS  idle gap between bytes, in bit periods, that aborts a
//                 partial word
//
// Ports
//   Clk      in   system clock, all logic on the rising edge
//   Reset    in   asynchronous, active-high reset
//   uart_rx  in   serial line, idle high, asynchronous to Clk
//   Data40   out  last complete 40-bit word, stable between Rx_Done pulses
//   Rx_Done  out  one-cycle pulse when Data40 is updated
//   Rx_Err   out  one-cycle pulse on stop-bit error or inter-byte timeout
// ----------------------------------------------------------------------------
module uart_rx_data40 #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        uart_rx,
    output logic [39:0] Data40,
    output logic        Rx_Done,
    output logic        Rx_Err
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
    localparam int unsigned HALF     = BAUD_DIV / 2;
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;

    // One extra count of headroom so BAUD_DIV-1 and TO_LIMIT always fit.
    localparam int unsigned BAUD_W = $clog2(BAUD_DIV + 1);
    localparam int unsigned TO_W   = $clog2(TO_LIMIT + 1);

    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state;
    state_t state_next;

    // Line synchroniser and edge register
    logic sync1;
    logic sync2;
    logic line_prev;
    logic fall;

    // Bit timing and byte shifter
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;

    // Word assembly and inter-byte timeout
    logic [31:0]     hold;
    logic [2:0]      byte_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            timeout_hit;

    // FSM control strobes
    logic baud_clr;
    logic shift_en;
    logic stop_en;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser plus one edge register. All three reset to the
    // idle (high) level so a reset never fabricates a start edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= uart_rx;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    assign fall = line_prev & ~sync2;

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        baud_clr   = 1'b0;
        shift_en   = 1'b0;
        stop_en    = 1'b0;

        case (state)
            IDLE: begin
                if (fall) begin
                    state_next = START;
                    baud_clr   = 1'b1;
                end
            end

            START: begin
                // Re-check the line mid start bit; a high level here means
                // the edge was a glitch and is silently ignored.
                if (baud_cnt == HALF_LAST) begin
                    if (!sync2) begin
                        state_next = DATA;
                        baud_clr   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            DATA: begin
                if (baud_cnt == FULL_LAST) begin
                    shift_en = 1'b1;
                    baud_clr = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end

            STOP: begin
                // Return to IDLE at the stop sample so a start edge in the
                // second half of the stop bit is caught.
                if (baud_cnt == FULL_LAST) begin
                    stop_en    = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Bit timing and byte shifter (LSB first)
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            if (state == IDLE || baud_clr) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end

            if (state != DATA) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (shift_en) begin
                shift <= {sync2, shift[7:1]};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Inter-byte timeout: counts idle cycles only while a word is partially
    // assembled; any start edge restarts it.
    // ------------------------------------------------------------------------
    assign timeout_hit = (state == IDLE) && (byte_cnt != 3'd0) && !fall &&
                         (to_cnt == TO_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            to_cnt <= '0;
        end else begin
            if (state != IDLE || fall || byte_cnt == 3'd0 || timeout_hit) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Word assembly and output strobes. Only bytes 1..4 need holding; the
    // fifth byte goes straight from the shifter into Data40[39:32].
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hold     <= '0;
            byte_cnt <= '0;
            Data40   <= '0;
            Rx_Done  <= 1'b0;
            Rx_Err   <= 1'b0;
        end else begin
            Rx_Done <= 1'b0;
            Rx_Err  <= 1'b0;

            if (stop_en) begin
                if (sync2) begin
                    if (byte_cnt == 3'd4) begin
                        Data40   <= {shift, hold};
                        byte_cnt <= '0;
                        Rx_Done  <= 1'b1;
                    end else begin
                        hold[{byte_cnt[1:0], 3'b000} +: 8] <= shift;
                        byte_cnt <= byte_cnt + 3'd1;
                    end
                end else begin
                    byte_cnt <= '0;
                    Rx_Err   <= 1'b1;
                end
            end else if (timeout_hit) begin
                byte_cnt <= '0;
                Rx_Err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_data40.sv
`timescale 1ns/1ps

module tb_uart_rx_data40;

    // 50 MHz clock; BAUD raised to keep the run short: BAUD_DIV = 40,
    // HALF = 20, one bit = 800 ns.
    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned BAUD     = 1_250_000;
    localparam int unsigned TO_BITS  = 20;
    localparam int          BIT      = 800;
    localparam int          HALF     = 20;
    localparam int          DIV      = 40;

    logic        clk;
    logic        rst;
    logic        rx;
    logic [39:0] data40;
    logic        rx_done;
    logic        rx_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Monitor state
    int          done_cnt   = 0;
    int          err_cnt    = 0;
    int          viol_cnt   = 0;
    time         done_time  = 0;
    logic        prev_done  = 1'b0;
    logic        prev_err   = 1'b0;
    logic [39:0] prev_data  = '0;

    uart_rx_data40 #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .TIMEOUT_BITS (TO_BITS)
    ) dut (
        .Clk     (clk),
        .Reset   (rst),
        .uart_rx (rx),
        .Data40  (data40),
        .Rx_Done (rx_done),
        .Rx_Err  (rx_err)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        total_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Pulse counting and invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            done_time = $time;
        end
        if (rx_err) err_cnt++;
        if (rx_done && rx_err) viol_cnt++;
        if (rx_done && prev_done) viol_cnt++;
        if (rx_err && prev_err) viol_cnt++;
        if (!rst && !rx_done && data40 !== prev_data) viol_cnt++;
        prev_done = rx_done;
        prev_err  = rx_err;
        prev_data = data40;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        #(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT);
        end
        rx = stop;
        #(BIT);
        rx = 1'b1;
        if (!stop) #(BIT);
    endtask

    task automatic send_word(input logic [39:0] w);
        for (int i = 0; i < 5; i++) begin
            send_byte(w[8*i +: 8], 1'b1);
        end
    endtask

    int  d0;
    int  e0;
    time t_start;
    int  lat;

    initial begin
        rx  = 1'b1;
        rst = 1'b1;
        #100;
        check("reset_data40",  data40, 40'h0);
        check("reset_rx_done", {39'b0, rx_done}, 40'h0);
        check("reset_rx_err",  {39'b0, rx_err}, 40'h0);
        rst = 1'b0;
        #(2*BIT);

        // 1: single word, plus latency of the final frame
        for (int i = 0; i < 4; i++) send_byte(8'h9a - 8'h22 * 8'(i), 1'b1);
        t_start = $time;
        send_byte(8'h12, 1'b1);
        #(BIT);
        check("w1_data",      data40, 40'h123456789a);
        check("w1_done_cnt",  40'(done_cnt), 40'd1);
        check("w1_err_cnt",   40'(err_cnt), 40'd0);
        lat = int'((done_time - t_start) / 20);
        check("w1_latency_ok", {39'b0, (lat >= HALF + 9*DIV + 1) && (lat <= HALF + 9*DIV + 5)}, 40'h1);

        // 2: 20 us gap, second word; Data40 must hold meanwhile
        #20000;
        check("w2_hold_gap", data40, 40'h123456789a);
        send_byte(8'h21, 1'b1);
        send_byte(8'h43, 1'b1);
        check("w2_hold_mid", data40, 40'h123456789a);
        send_byte(8'h65, 1'b1);
        send_byte(8'h87, 1'b1);
        send_byte(8'ha9, 1'b1);
        #(BIT);
        check("w2_data",     data40, 40'ha987654321);
        check("w2_done_cnt", 40'(done_cnt), 40'd2);
        check("w2_err_cnt",  40'(err_cnt), 40'd0);

        // 3: 100 ns glitch ignored
        rx = 1'b0;
        #100;
        rx = 1'b1;
        #(4*BIT);
        check("glitch_done_cnt", 40'(done_cnt), 40'd2);
        check("glitch_err_cnt",  40'(err_cnt), 40'd0);
        send_word(40'h01efbeadde);
        #(BIT);
        check("w3_data",     data40, 40'h01efbeadde);
        check("w3_done_cnt", 40'(done_cnt), 40'd3);

        // 4: third byte with a bad stop bit
        send_byte(8'ha1, 1'b1);
        send_byte(8'hb2, 1'b1);
        send_byte(8'hc3, 1'b0);
        check("stop_err_cnt",   40'(err_cnt), 40'd1);
        check("stop_err_data",  data40, 40'h01efbeadde);
        check("stop_err_done",  40'(done_cnt), 40'd3);
        send_word(40'h5544332211);
        #(BIT);
        check("w4_data",     data40, 40'h5544332211);
        check("w4_done_cnt", 40'(done_cnt), 40'd4);

        // 5: two bytes then a long idle gap
        send_byte(8'h77, 1'b1);
        send_byte(8'h66, 1'b1);
        d0 = done_cnt;
        e0 = err_cnt;
        #(18*BIT);
        check("to_not_early", 40'(err_cnt), 40'(e0));
        #(7*BIT);
        check("to_err_cnt",  40'(err_cnt), 40'(e0 + 1));
        check("to_done_cnt", 40'(done_cnt), 40'(d0));
        check("to_data_held", data40, 40'h5544332211);
        send_word(40'h0504030201);
        #(BIT);
        check("w5_data",     data40, 40'h0504030201);
        check("w5_done_cnt", 40'(done_cnt), 40'(d0 + 1));

        // 6: reset in the data bits of byte 2
        send_byte(8'h99, 1'b1);
        rx = 1'b0;
        #(BIT);
        rx = 1'b1;
        #(2*BIT);
        rx = 1'b0;
        #(BIT);
        rst = 1'b1;
        #40;
        check("rst_mid_data40", data40, 40'h0);
        check("rst_mid_done",   {39'b0, rx_done}, 40'h0);
        check("rst_mid_err",    {39'b0, rx_err}, 40'h0);
        #60;
        rx  = 1'b1;
        rst = 1'b0;
        #(2*BIT);
        d0 = done_cnt;
        send_word(40'h4b3c2d1e0f);
        #(BIT);
        check("w6_data",     data40, 40'h4b3c2d1e0f);
        check("w6_done_cnt", 40'(done_cnt), 40'(d0 + 1));

        check("pulse_invariants", 40'(viol_cnt), 40'd0);
        check("total_err_cnt",    40'(err_cnt), 40'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
